// File: rtl/cpu_phase_clock_gen.sv
// cpu_phase_clock_gen: phi1/phi2 and slow-bus clock enables with slow-access cycle stretching
module cpu_phase_clock_gen #(
    parameter int PH_WIDTH       = 8,
    parameter int NUM_SLOW       = 2,
    parameter int RESET_PHASE_M1 = 4,
    parameter int RESET_RATIO_M1 = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cfg_valid,
    input  logic                cfg_write,
    input  logic [1:0]          cfg_select,
    input  logic [31:0]         cfg_wdata,
    output logic [31:0]         cfg_rdata,
    input  logic                cpu_slow_access,
    input  logic [2:0]          cpu_slow_channel,
    output logic [1:0]          phi,
    output logic                enable_cpu,
    output logic                phase_tick,
    output logic [NUM_SLOW-1:0] slow_high,
    output logic [NUM_SLOW-1:0] slow_rise,
    output logic [NUM_SLOW-1:0] slow_fall,
    output logic                reset_cpu
);
    typedef enum logic {PHI1, PHI2} state_t;
    state_t                  state, state_next;
    logic                    stretch, stretch_next;
    logic [2:0]              stretch_ch, stretch_ch_next, ch;
    logic [PH_WIDTH-1:0]     phase_m1, active_phase_m1, pcnt;
    logic                    halt, stall_inc, cfg_wr;
    logic [15:0]             stall_count;
    logic [4*NUM_SLOW-1:0]   ratios;
    logic [7:0]              rise8, fall8;
    logic [31:0]             sel0_image;
    logic                    unused;

    assign unused     = ^cfg_wdata;
    assign cfg_wr     = cfg_valid & cfg_write;
    assign phase_tick = pcnt == active_phase_m1;
    assign phi        = state == PHI2 ? 2'b10 : 2'b01;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            pcnt            <= '0;
            active_phase_m1 <= PH_WIDTH'(RESET_PHASE_M1);
            phase_m1        <= PH_WIDTH'(RESET_PHASE_M1);
            reset_cpu       <= 1'b0;
            halt            <= 1'b0;
            stall_count     <= '0;
        end else begin
            pcnt <= phase_tick ? '0 : pcnt + 1'b1;
            if (phase_tick) active_phase_m1 <= phase_m1;
            if (cfg_wr && cfg_select == 2'd0) begin
                phase_m1  <= cfg_wdata[PH_WIDTH-1:0];
                reset_cpu <= cfg_wdata[16];
                halt      <= cfg_wdata[17];
            end
            if (cfg_wr && cfg_select == 2'd2) stall_count <= '0;
            else if (stall_inc && stall_count != 16'hFFFF) stall_count <= stall_count + 1'b1;
        end

    for (genvar k = 0; k < NUM_SLOW; k++) begin : g_slow
        logic [3:0] ratio, active_ratio, scnt;
        logic       high, wrap;
        assign wrap         = phase_tick && scnt == active_ratio;
        assign slow_rise[k] = wrap & ~high;
        assign slow_fall[k] = wrap & high;
        assign slow_high[k] = high;
        assign ratios[4*k+:4] = ratio;
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                ratio        <= 4'(RESET_RATIO_M1);
                active_ratio <= 4'(RESET_RATIO_M1);
                scnt         <= '0;
                high         <= 1'b0;
            end else begin
                if (phase_tick) scnt <= wrap ? '0 : scnt + 1'b1;
                if (wrap) begin
                    active_ratio <= ratio;
                    high         <= ~high;
                end
                if (cfg_wr && cfg_select == 2'd1) ratio <= cfg_wdata[4*k+:4];
            end
    end

    always_comb begin
        rise8 = '0;
        fall8 = '0;
        rise8[NUM_SLOW-1:0] = slow_rise;
        fall8[NUM_SLOW-1:0] = slow_fall;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state      <= PHI1;
            stretch    <= 1'b0;
            stretch_ch <= '0;
        end else begin
            state      <= state_next;
            stretch    <= stretch_next;
            stretch_ch <= stretch_ch_next;
        end

    // A stretched cycle waits in phi1 for the slow rise and in phi2 for the slow fall
    always_comb begin
        state_next      = state;
        stretch_next    = stretch;
        stretch_ch_next = stretch_ch;
        enable_cpu      = 1'b0;
        stall_inc       = 1'b0;
        ch              = stretch ? stretch_ch : cpu_slow_channel;
        if (phase_tick && !halt) begin
            if (state == PHI1) begin
                if (cpu_slow_access || stretch) begin
                    stretch_next    = 1'b1;
                    stretch_ch_next = ch;
                    state_next      = rise8[ch] ? PHI2 : PHI1;
                    stall_inc       = !rise8[ch];
                end else begin
                    state_next = PHI2;
                end
            end else if (!stretch || fall8[stretch_ch]) begin
                state_next   = PHI1;
                enable_cpu   = 1'b1;
                stretch_next = 1'b0;
            end else begin
                stall_inc = 1'b1;
            end
        end
    end

    always_comb begin
        sel0_image = '0;
        sel0_image[PH_WIDTH-1:0] = phase_m1;
        sel0_image[16] = reset_cpu;
        sel0_image[17] = halt;
    end

    assign cfg_rdata = cfg_select == 2'd0 ? sel0_image :
                       cfg_select == 2'd1 ? 32'(ratios) :
                       cfg_select == 2'd2 ? {16'h0, stall_count} : '0;
endmodule

// File: tb/tb_cpu_phase_clock_gen.sv
// tb_cpu_phase_clock_gen: directed scenarios plus random traffic checked against a countdown model
module tb_cpu_phase_clock_gen;
    localparam int PW = 8;
    localparam int NS = 2;
    localparam int RP = 4;
    localparam int RR = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_valid = 1'b0, cfg_write = 1'b0;
    logic [1:0]    cfg_select = 2'd0;
    logic [31:0]   cfg_wdata = '0;
    logic [31:0]   cfg_rdata;
    logic          cpu_slow_access = 1'b0;
    logic [2:0]    cpu_slow_channel = 3'd0;
    logic [1:0]    phi;
    logic          enable_cpu, phase_tick, reset_cpu;
    logic [NS-1:0] slow_high, slow_rise, slow_fall;

    cpu_phase_clock_gen #(.PH_WIDTH(PW), .NUM_SLOW(NS), .RESET_PHASE_M1(RP), .RESET_RATIO_M1(RR)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_write(cfg_write),
        .cfg_select(cfg_select), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .cpu_slow_access(cpu_slow_access), .cpu_slow_channel(cpu_slow_channel),
        .phi(phi), .enable_cpu(enable_cpu), .phase_tick(phase_tick),
        .slow_high(slow_high), .slow_rise(slow_rise), .slow_fall(slow_fall), .reset_cpu(reset_cpu)
    );

    always #5 clk = ~clk;

    int cmp = 0, err = 0, cyc = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Model: countdowns to the next phase tick and to each slow toggle
    int          m_left, m_sleft[NS], m_ratio[NS], m_pm1, m_ch, m_stall;
    logic [NS-1:0] m_high;
    bit          m_phi2, m_stretch, m_halt, m_rcpu;

    task automatic model_reset();
        m_left = RP; m_pm1 = RP; m_high = '0; m_phi2 = 0; m_stretch = 0;
        m_ch = 0; m_stall = 0; m_halt = 0; m_rcpu = 0;
        for (int k = 0; k < NS; k++) begin m_sleft[k] = RR; m_ratio[k] = RR; end
    endtask

    bit            e_tick, e_en, e_inc;
    logic [NS-1:0] e_rise, e_fall;
    logic [31:0]   e_rd;
    int            e_ch;

    always @(negedge clk) begin
        if (!reset_n) begin model_reset(); cyc = 0; end
        e_tick = m_left == 0;
        for (int k = 0; k < NS; k++) begin
            e_rise[k] = e_tick && m_sleft[k] == 0 && !m_high[k];
            e_fall[k] = e_tick && m_sleft[k] == 0 && m_high[k];
        end
        e_ch = m_stretch ? m_ch : int'(cpu_slow_channel);
        e_en = e_tick && !m_halt && m_phi2 && (!m_stretch || e_fall[m_ch]);
        e_rd = 0;
        if (cfg_select == 2'd0) e_rd = 32'(m_pm1) | (32'(m_rcpu) << 16) | (32'(m_halt) << 17);
        if (cfg_select == 2'd1) for (int k = 0; k < NS; k++) e_rd = e_rd | (32'(m_ratio[k]) << (4 * k));
        if (cfg_select == 2'd2) e_rd = 32'(m_stall);
        check("phase_tick", phase_tick, e_tick);
        check("enable_cpu", enable_cpu, e_en);
        check("phi", phi, m_phi2 ? 2'b10 : 2'b01);
        check("slow_high", slow_high, m_high);
        check("slow_rise", slow_rise, e_rise);
        check("slow_fall", slow_fall, e_fall);
        check("reset_cpu", reset_cpu, m_rcpu);
        check("cfg_rdata", cfg_rdata, e_rd);
        if (reset_n) begin
            m_left = e_tick ? m_pm1 : m_left - 1;
            for (int k = 0; k < NS; k++)
                if (e_tick) begin
                    if (m_sleft[k] == 0) begin m_high[k] = !m_high[k]; m_sleft[k] = m_ratio[k]; end
                    else m_sleft[k]--;
                end
            e_inc = 0;
            if (e_tick && !m_halt) begin
                if (!m_phi2) begin
                    if (cpu_slow_access || m_stretch) begin
                        if (e_rise[e_ch]) m_phi2 = 1; else e_inc = 1;
                        m_stretch = 1; m_ch = e_ch;
                    end else m_phi2 = 1;
                end else if (!m_stretch || e_fall[m_ch]) begin
                    m_phi2 = 0; m_stretch = 0;
                end else e_inc = 1;
            end
            if (cfg_valid && cfg_write && cfg_select == 2'd2) m_stall = 0;
            else if (e_inc && m_stall < 65535) m_stall++;
            if (cfg_valid && cfg_write && cfg_select == 2'd0) begin
                m_pm1 = int'(cfg_wdata[PW-1:0]); m_rcpu = cfg_wdata[16]; m_halt = cfg_wdata[17];
            end
            if (cfg_valid && cfg_write && cfg_select == 2'd1)
                for (int k = 0; k < NS; k++) m_ratio[k] = int'((cfg_wdata >> (4 * k)) & 32'hF);
            cyc++;
        end
    end

    task automatic at_cycle(int c);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (cyc < c && n < 2000);
        cmp++;
        if (cyc != c) begin err++; $display("FAIL at_cycle got=%0d want=%0d", cyc, c); end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 0; cfg_valid = 0; cfg_write = 0; cfg_select = 0; cfg_wdata = 0;
        cpu_slow_access = 0; cpu_slow_channel = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1;
    endtask

    task automatic wr(logic [1:0] sel, logic [31:0] data);
        cfg_valid = 1; cfg_write = 1; cfg_select = sel; cfg_wdata = data;
    endtask

    task automatic scen1_checks();
        at_cycle(4);  @(negedge clk); check("s1_tick4", phase_tick, 1);
        at_cycle(5);  @(negedge clk); check("s1_phi5", phi, 2'b10);
        at_cycle(9);  @(negedge clk); check("s1_en9", enable_cpu, 1); check("s1_rise9", slow_rise[0], 1);
        at_cycle(19); @(negedge clk); check("s1_en19", enable_cpu, 1); check("s1_fall19", slow_fall[0], 1);
    endtask

    initial begin
        do_reset();
        scen1_checks();

        do_reset();
        at_cycle(10); cpu_slow_access = 1; cpu_slow_channel = 0;
        at_cycle(15); cpu_slow_access = 0;
        at_cycle(29); @(negedge clk); check("s2_phi29", phi, 2'b01);
        at_cycle(30); @(negedge clk); check("s2_phi30", phi, 2'b10);
        at_cycle(39); @(negedge clk); check("s2_en39", enable_cpu, 1); check("s2_fall39", slow_fall[0], 1);
        at_cycle(40); cfg_select = 2; @(negedge clk); check("s2_stall", cfg_rdata, 4);

        do_reset();
        at_cycle(2);  wr(0, 9);
        at_cycle(3);  cfg_valid = 0; @(negedge clk); check("s3_rd", cfg_rdata, 32'h9);
        at_cycle(4);  @(negedge clk); check("s3_tick4", phase_tick, 1);
        at_cycle(13); @(negedge clk); check("s3_tick13", phase_tick, 0);
        at_cycle(14); @(negedge clk); check("s3_tick14", phase_tick, 1);
        at_cycle(24); @(negedge clk); check("s3_tick24", phase_tick, 1);

        do_reset();
        at_cycle(6);  wr(0, 32'h20004);
        at_cycle(7);  cfg_valid = 0;
        at_cycle(9);  @(negedge clk); check("s4_en9", enable_cpu, 0); check("s4_phi9", phi, 2'b10);
        at_cycle(19); @(negedge clk); check("s4_fall19", slow_fall[0], 1);
        at_cycle(20); wr(0, 32'h4);
        at_cycle(21); cfg_valid = 0;
        at_cycle(24); @(negedge clk); check("s4_en24", enable_cpu, 1);

        do_reset();
        at_cycle(1);  wr(1, 32'h31);
        at_cycle(2);  cfg_valid = 0; cfg_select = 1; @(negedge clk); check("s5_rd", cfg_rdata, 32'h31);
        at_cycle(19); @(negedge clk); check("s5_fall19", slow_fall[1], 0);
        at_cycle(29); @(negedge clk); check("s5_fall29", slow_fall[1], 1);
        at_cycle(49); @(negedge clk); check("s5_rise49", slow_rise[1], 1); check("s5_rise0", slow_rise[0], 1);

        do_reset();
        at_cycle(10); cpu_slow_access = 1; cpu_slow_channel = 0;
        at_cycle(15); cpu_slow_access = 0;
        at_cycle(22); reset_n = 0;
        @(negedge clk); check("s6_phi", phi, 2'b01); check("s6_en", enable_cpu, 0);
        @(posedge clk); #1; reset_n = 1; cfg_select = 2;
        @(negedge clk); check("s6_stall", cfg_rdata, 0);
        cfg_select = 0;
        scen1_checks();

        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 999) == 0) begin
                reset_n = 0;
                @(posedge clk); #1;
                reset_n = 1;
            end
            cfg_valid  = $urandom_range(0, 9) == 0;
            cfg_write  = 1'($urandom_range(0, 1));
            cfg_select = 2'($urandom_range(0, 3));
            case (cfg_select)
                2'd0: cfg_wdata = 32'($urandom_range(0, 6)) | (32'($urandom_range(0, 1)) << 16)
                                  | (32'($urandom_range(0, 3) == 0) << 17);
                2'd1: cfg_wdata = 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 3)) << 4);
                default: cfg_wdata = $urandom;
            endcase
            cpu_slow_access  = $urandom_range(0, 2) == 0;
            cpu_slow_channel = 3'($urandom_range(0, NS - 1));
        end
        @(posedge clk); #1;
        cfg_valid = 0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule

// File: doc/cpu_phase_clock_gen.md
# cpu_phase_clock_gen

Parametrised CPU and slow-bus clock-enable generator for the retro-micro family. It divides the system clock into CPU half-cycles (phi1/phi2) and into NUM_SLOW independent slow-bus clocks, such as the 1MHz bus. When the CPU accesses a slow bus, it stretches the CPU cycle so that phi2 aligns with that bus's high phase. It sits between the CSR fabric and the CPU/peripheral clock-enable distribution, and it adds shadowed reconfiguration, per-channel ratios, halt and stall counting.

## Interface
Parameters:
- PH_WIDTH, 8: width of phase divider counter (max 16).
- NUM_SLOW, 2: number of slow-bus channels (1..8).
- RESET_PHASE_M1, 4: reset value of clk cycles per CPU phase, minus one.
- RESET_RATIO_M1, 1: reset value of CPU phases per slow half-cycle, minus one, for every channel.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  CSR access strobe (single cycle, always accepted).
- cfg_write  in  1  1=write, 0=read.
- cfg_select  in  2  register: 0 control, 1 slow ratios, 2 stall count.
- cfg_wdata  in  32  write data.
- cfg_rdata  out  32  combinational read data for cfg_select; unused bits 0.
- cpu_slow_access  in  1  CPU address decodes to a slow bus (valid in phi1).
- cpu_slow_channel  in  3  slow channel index for the access; only index < NUM_SLOW is legal.
- phi  out  2  one-hot phase: 01 phi1, 10 phi2.
- enable_cpu  out  1  one-cycle pulse at the end of phi2 (CPU cycle complete).
- phase_tick  out  1  one-cycle pulse at the end of every phase period.
- slow_high  out  NUM_SLOW  registered slow-clock levels.
- slow_rise  out  NUM_SLOW  one-cycle pulse; the slow clock goes high next cycle.
- slow_fall  out  NUM_SLOW  one-cycle pulse; the slow clock goes low next cycle.
- reset_cpu  out  1  registered CPU reset from control bit 16.

## Operation
- Registers:
  - sel0 holds [PH_WIDTH-1:0] phase_m1, [16] reset_cpu, [17] halt.
  - sel1 holds ratio_m1 for channel k in bits [4k+3:4k].
  - sel2 holds the 16-bit stall_count. A write of any data clears it.
- Reset values: phase_m1=RESET_PHASE_M1; ratios=RESET_RATIO_M1; reset_cpu=0; halt=0; stall_count=0.
- Phase counter:
  - pcnt counts 0..active_phase_m1. phase_tick = (pcnt==active_phase_m1).
  - pcnt wraps to 0 on phase_tick, and active_phase_m1 is loaded from phase_m1 at that point (shadowed).
  - If phase_m1=0, phase_tick is asserted every cycle.
- Slow channel k:
  - scnt[k] advances only on phase_tick. At phase_tick with scnt[k]==active_ratio_m1[k], scnt[k] goes to 0, active_ratio is reloaded and slow_high[k] toggles.
  - slow_rise[k] is asserted on that cycle if slow_high[k] was 0; slow_fall[k] if it was 1.
  - Slow channels run regardless of halt.
- Phase state machine (PHI1, PHI2), plus a stretch flag and a 3-bit stretch_ch:
  - PHI1, at phase_tick, not halted:
    - If cpu_slow_access is asserted this cycle, or stretch is already set: set stretch and latch stretch_ch (first assertion only). Move to PHI2 only when slow_rise[stretch_ch] is asserted; otherwise hold and count a stall.
    - Otherwise move to PHI2.
  - PHI2, at phase_tick, not halted:
    - Not stretched: move to PHI1 with enable_cpu=1.
    - Stretched: move to PHI1 with enable_cpu=1 and clear stretch only on slow_fall[stretch_ch]. Otherwise hold and count a stall.
  - halt=1: phase_tick is ignored by the state machine and no stalls are counted. phi and stretch hold.
- stall_count saturates at 0xFFFF.
- A cfg clear of stall_count and a simultaneous increment: the clear wins.

## Timing
- enable_cpu, phase_tick, slow_rise and slow_fall are combinational from registered state and occur in the same cycle. phi and slow_high update the following cycle.
- A cfg write takes effect on the register the next cycle:
  - phase_m1 is used from the next phase wrap.
  - ratio_m1 is used from that channel's next slow wrap.
  - reset_cpu and halt act immediately.
- Output reset values: phi=01, enable_cpu=0, phase_tick=0 (1 if RESET_PHASE_M1=0), slow_high=0, slow_rise=0, slow_fall=0, reset_cpu=0, cfg_rdata = sel0 reset image.
- Asserting reset mid-stretch clears stretch and returns phi to 01 asynchronously.

## Test plan
- Defaults, no access (cycle 0 = first cycle after reset release) -> phase_tick at cycles 4,9,14…; phi=10 from cycle 5; enable_cpu at 9,19,29; slow_rise[0] at 9,29; slow_fall[0] at 19,39.
- cpu_slow_access=1, channel 0, held during phi1 cycles 10–14 -> phi1 held through ticks 14,19,24; phi2 from cycle 30; enable_cpu at cycle 39 (coincident with slow_fall[0]); stall_count=4.
- Write phase_m1=9 at cycle 2 -> the current period still ends at cycle 4; subsequent ticks at cycles 14,24; read sel0 returns 0x00000009.
- Write halt=1 during phi2 -> phi stays 10 and enable_cpu stays 0; slow_rise/slow_fall keep their cadence; clearing halt resumes with enable_cpu at the next tick.
- Write sel1 with channel 1 ratio_m1=3 -> slow_high[1] half-period becomes 4 phases from its next wrap; channel 0 unchanged.
- Assert reset_n low mid-stretch, then release -> all outputs at reset values, stretch cleared, stall_count=0; behaviour matches scenario 1.
